// File: rtl/re_pkg.sv
// Shared state/phase encodings and default limits for the row-enable controller.
package re_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StExpose  = 2'd1,
    StReadout = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PhSettle  = 2'd0,
    PhConvert = 2'd1,
    PhRelease = 2'd2
  } phase_e;

  localparam int unsigned RowsDef   = 2;
  localparam int unsigned ExpWDef   = 5;
  localparam int unsigned ExpMinDef = 2;
  localparam int unsigned ExpMaxDef = 30;
  localparam int unsigned ExpRstDef = 10;

  // Row index width, kept at least one bit wide.
  function automatic int unsigned row_w(int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/re_control_nrow_if.sv
// Control/status bundle of re_control_nrow. i_Cont exists only with RE_CONT_MODE_EN.
interface re_control_nrow_if #(
  parameter int unsigned ROWS  = re_pkg::RowsDef,
  parameter int unsigned EXP_W = re_pkg::ExpWDef
);
  localparam int unsigned RowW = re_pkg::row_w(ROWS);

  logic             i_Init;
  logic             i_Exp_increase;
  logic             i_Exp_decrease;
`ifdef RE_CONT_MODE_EN
  logic             i_Cont;
`endif
  logic [ROWS-1:0]  o_NRE;
  logic             o_ADC;
  logic             o_Expose;
  logic             o_Erase;
  logic [EXP_W-1:0] o_count_time;
  logic [1:0]       o_Main_FSM;
  logic [RowW-1:0]  o_Row;

`ifdef RE_CONT_MODE_EN
  modport master (
    output i_Init, i_Exp_increase, i_Exp_decrease, i_Cont,
    input  o_NRE, o_ADC, o_Expose, o_Erase, o_count_time, o_Main_FSM, o_Row
  );
  modport slave (
    input  i_Init, i_Exp_increase, i_Exp_decrease, i_Cont,
    output o_NRE, o_ADC, o_Expose, o_Erase, o_count_time, o_Main_FSM, o_Row
  );
`else
  modport master (
    output i_Init, i_Exp_increase, i_Exp_decrease,
    input  o_NRE, o_ADC, o_Expose, o_Erase, o_count_time, o_Main_FSM, o_Row
  );
  modport slave (
    input  i_Init, i_Exp_increase, i_Exp_decrease,
    output o_NRE, o_ADC, o_Expose, o_Erase, o_count_time, o_Main_FSM, o_Row
  );
`endif

endinterface

// File: rtl/re_exp_time.sv
// Exposure-time register: registered rising-edge detect on the up/down buttons, saturating step.
module re_exp_time
  import re_pkg::*;
#(
  parameter int unsigned EXP_W   = ExpWDef,
  parameter int unsigned EXP_MIN = ExpMinDef,
  parameter int unsigned EXP_MAX = ExpMaxDef,
  parameter int unsigned EXP_RST = ExpRstDef
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Exp_increase,
  input  logic             i_Exp_decrease,
  input  logic             i_Enable,
  output logic [EXP_W-1:0] o_count_time
);

  logic             inc_q, dec_q;
  logic             inc_edge, dec_edge;
  logic [EXP_W-1:0] time_q, time_d;

  assign inc_edge = i_Exp_increase & ~inc_q;
  assign dec_edge = i_Exp_decrease & ~dec_q;

  // Simultaneous edges cancel; edges while disabled are dropped, not queued.
  always_comb begin
    time_d = time_q;
    if (i_Enable && inc_edge && !dec_edge) begin
      if (time_q < EXP_W'(EXP_MAX)) time_d = time_q + EXP_W'(1);
    end else if (i_Enable && dec_edge && !inc_edge) begin
      if (time_q > EXP_W'(EXP_MIN)) time_d = time_q - EXP_W'(1);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      time_q <= EXP_W'(EXP_RST);
    end else begin
      inc_q  <= i_Exp_increase;
      dec_q  <= i_Exp_decrease;
      time_q <= time_d;
    end
  end

  assign o_count_time = time_q;

endmodule

// File: rtl/re_control_nrow.sv
// Frame controller: IDLE/erase -> EXPOSE for o_count_time cycles -> 3-cycle-per-row READOUT.
// Define RE_CONT_MODE_EN to add i_Cont (back-to-back frames with a single IDLE cycle between).
module re_control_nrow
  import re_pkg::*;
#(
  parameter int unsigned ROWS    = RowsDef,
  parameter int unsigned EXP_W   = ExpWDef,
  parameter int unsigned EXP_MIN = ExpMinDef,
  parameter int unsigned EXP_MAX = ExpMaxDef,
  parameter int unsigned EXP_RST = ExpRstDef
) (
  input logic            i_Clock,
  input logic            i_Reset,
  re_control_nrow_if.slave bus
);

  localparam int unsigned    RowW    = row_w(ROWS);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] count_time;
  logic             restart;
  logic [ROWS-1:0]  nre_q, nre_d;
  logic             adc_q, adc_d, expose_q, expose_d, erase_q, erase_d;

  re_exp_time #(
    .EXP_W  (EXP_W),
    .EXP_MIN(EXP_MIN),
    .EXP_MAX(EXP_MAX),
    .EXP_RST(EXP_RST)
  ) u_exp_time (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Exp_increase(bus.i_Exp_increase),
    .i_Exp_decrease(bus.i_Exp_decrease),
    .i_Enable      (state_q == StIdle),
    .o_count_time  (count_time)
  );

`ifdef RE_CONT_MODE_EN
  // Set for exactly the one IDLE cycle that follows a readout ending with i_Cont high.
  logic restart_q;
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) restart_q <= 1'b0;
    else          restart_q <= bus.i_Cont && (state_q == StReadout) && (state_d == StIdle);
  end
  assign restart = restart_q;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= StIdle;
      phase_q <= PhSettle;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.i_Init || restart) begin
          state_d = StExpose;
          cnt_d   = count_time;
        end
      end
      StExpose: begin
        if (cnt_q <= EXP_W'(1)) begin
          state_d = StReadout;
          phase_d = PhSettle;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q - EXP_W'(1);
        end
      end
      StReadout: begin
        case (phase_q)
          PhSettle:  phase_d = PhConvert;
          PhConvert: phase_d = PhRelease;
          default: begin
            phase_d = PhSettle;
            if (row_q == LastRow) begin
              state_d = StIdle;
              row_d   = '0;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    erase_d  = (state_d == StIdle);
    expose_d = (state_d == StExpose);
    adc_d    = (state_d == StReadout) && (phase_d == PhConvert);
    nre_d    = '1;
    if ((state_d == StReadout) && (phase_d != PhRelease)) nre_d[row_d] = 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      nre_q    <= '1;
      adc_q    <= 1'b0;
      expose_q <= 1'b0;
      erase_q  <= 1'b1;
    end else begin
      nre_q    <= nre_d;
      adc_q    <= adc_d;
      expose_q <= expose_d;
      erase_q  <= erase_d;
    end
  end

  assign bus.o_NRE        = nre_q;
  assign bus.o_ADC        = adc_q;
  assign bus.o_Expose     = expose_q;
  assign bus.o_Erase      = erase_q;
  assign bus.o_count_time = count_time;
  assign bus.o_Main_FSM   = state_q;
  assign bus.o_Row        = row_q;

endmodule

// File: tb/tb_re_control_nrow.sv
// Self-checking bench for re_control_nrow: ROWS=2 and ROWS=4 instances, button table, corner cases.
module tb_re_control_nrow;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  re_control_nrow_if #(.ROWS(2), .EXP_W(5)) bus2 ();
  re_control_nrow_if #(.ROWS(4), .EXP_W(5)) bus4 ();

  re_control_nrow #(.ROWS(2)) dut2 (
    .i_Clock(clk),
    .i_Reset(rst_n),
    .bus    (bus2.slave)
  );

  re_control_nrow #(.ROWS(4)) dut4 (
    .i_Clock(clk),
    .i_Reset(rst_n),
    .bus    (bus4.slave)
  );

  int total = 0;
  int bad   = 0;
  int model_ct;

  // {fsm[1:0], expose, erase, adc, nre[1:0], row} of the ROWS=2 instance
  typedef logic [7:0] obs_t;
  obs_t sbq[$];
  int   ctq[$];

  typedef struct {
    logic inc;
    logic dec;
    int   presses;
    int   hold;
    int   final_ct;
  } btn_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t obs2();
    return {bus2.o_Main_FSM, bus2.o_Expose, bus2.o_Erase, bus2.o_ADC, bus2.o_NRE, bus2.o_Row};
  endfunction

  // Full ROWS=2 frame started by i_Init, expected trace queued as the pulse is driven.
  task automatic run_frame2(input string tag, input int exp_len);
    obs_t e;
    int   k;
    bus2.i_Init = 1'b1;
    for (int i = 0; i < exp_len; i++) sbq.push_back({2'd1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0});
    for (int j = 0; j < 6; j++) begin
      logic [1:0] nre;
      logic       row;
      row = (j >= 3);
      nre = (j % 3 == 2) ? 2'b11 : (row ? 2'b01 : 2'b10);
      sbq.push_back({2'd2, 1'b0, 1'b0, (j % 3 == 1), nre, row});
    end
    sbq.push_back({2'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0});
    tick();
    bus2.i_Init = 1'b0;
    k = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("%s cycle %0d", tag, k), obs2(), e);
      k++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    btn_t vec[6];
    int   n;

    vec[0] = '{inc: 1'b1, dec: 1'b0, presses: 25, hold: 1, final_ct: 30};
    vec[1] = '{inc: 1'b0, dec: 1'b1, presses: 40, hold: 1, final_ct: 2};
    vec[2] = '{inc: 1'b1, dec: 1'b0, presses: 3,  hold: 1, final_ct: 5};
    vec[3] = '{inc: 1'b1, dec: 1'b0, presses: 1,  hold: 6, final_ct: 6};
    vec[4] = '{inc: 1'b1, dec: 1'b1, presses: 2,  hold: 1, final_ct: 6};
    vec[5] = '{inc: 1'b0, dec: 1'b1, presses: 1,  hold: 1, final_ct: 5};

    bus2.i_Init = 1'b0; bus2.i_Exp_increase = 1'b0; bus2.i_Exp_decrease = 1'b0;
    bus4.i_Init = 1'b0; bus4.i_Exp_increase = 1'b0; bus4.i_Exp_decrease = 1'b0;
`ifdef RE_CONT_MODE_EN
    bus2.i_Cont = 1'b0;
    bus4.i_Cont = 1'b0;
`endif

    #2 rst_n = 1'b0;
    #1;
    check("reset fsm", bus2.o_Main_FSM, 0);
    check("reset erase", bus2.o_Erase, 1);
    check("reset expose", bus2.o_Expose, 0);
    check("reset adc", bus2.o_ADC, 0);
    check("reset nre", bus2.o_NRE, 2'b11);
    check("reset row", bus2.o_Row, 0);
    check("reset count", bus2.o_count_time, 10);
    check("reset nre4", bus4.o_NRE, 4'hF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle holds", obs2(), {2'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0});
    model_ct = 10;

    run_frame2("frame10", 10);

    // Button table: per-press expectation queued at drive time, popped after release.
    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < vec[v].presses; p++) begin
        bus2.i_Exp_increase = vec[v].inc;
        bus2.i_Exp_decrease = vec[v].dec;
        if (vec[v].inc && !vec[v].dec)      model_ct = (model_ct < 30) ? model_ct + 1 : 30;
        else if (vec[v].dec && !vec[v].inc) model_ct = (model_ct > 2) ? model_ct - 1 : 2;
        ctq.push_back(model_ct);
        for (int h = 0; h < vec[v].hold; h++) tick();
        bus2.i_Exp_increase = 1'b0;
        bus2.i_Exp_decrease = 1'b0;
        tick();
        check($sformatf("vec%0d press%0d", v, p), bus2.o_count_time, ctq.pop_front());
      end
      check($sformatf("vec%0d final", v), bus2.o_count_time, vec[v].final_ct);
    end

    // Increase press during EXPOSE is dropped.
    bus2.i_Init = 1'b1;
    tick();
    bus2.i_Init = 1'b0;
    bus2.i_Exp_increase = 1'b1;
    tick();
    bus2.i_Exp_increase = 1'b0;
    n = 0;
    while (bus2.o_Main_FSM != 2'd0 && n < 40) begin
      tick();
      n++;
    end
    check("expose press frame end", bus2.o_Main_FSM, 0);
    tick();
    check("expose press ignored", bus2.o_count_time, model_ct);

    run_frame2("frame5", model_ct);

    // Reset during CONVERT of row 1.
    bus2.i_Init = 1'b1;
    tick();
    bus2.i_Init = 1'b0;
    n = 0;
    while (!(bus2.o_Main_FSM == 2'd2 && bus2.o_Row == 1'b1 && bus2.o_ADC) && n < 40) begin
      tick();
      n++;
    end
    check("reach convert row1", {bus2.o_Main_FSM, bus2.o_Row, bus2.o_ADC}, {2'd2, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    check("abort adc", bus2.o_ADC, 0);
    check("abort nre", bus2.o_NRE, 2'b11);
    check("abort count", bus2.o_count_time, 10);
    check("abort fsm", bus2.o_Main_FSM, 0);
    check("abort erase", bus2.o_Erase, 1);
    tick();
    rst_n = 1'b1;
    model_ct = 10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("no resume %0d", i), obs2(), {2'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0});
    end

    // ROWS=4 readout order and one-cold enables.
    bus4.i_Init = 1'b1;
    tick();
    bus4.i_Init = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("r4 expose %0d", i), {bus4.o_Main_FSM, bus4.o_Expose}, {2'd1, 1'b1});
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      logic [3:0] enr;
      logic [3:0] one;
      one = 4'b0001;
      enr = (j % 3 == 2) ? 4'hF : ~(one << (j / 3));
      check($sformatf("r4 nre %0d", j), bus4.o_NRE, enr);
      check($sformatf("r4 adc %0d", j), bus4.o_ADC, (j % 3 == 1));
      check($sformatf("r4 fsm %0d", j), bus4.o_Main_FSM, 2);
      check($sformatf("r4 onecold %0d", j), ($countones(~bus4.o_NRE) <= 1), 1);
      tick();
    end
    check("r4 idle", {bus4.o_Main_FSM, bus4.o_Erase}, {2'd0, 1'b1});

`ifdef RE_CONT_MODE_EN
    // Continuous capture: one IDLE gap, restart without i_Init, stop once i_Cont drops.
    bus2.i_Cont = 1'b1;
    bus2.i_Init = 1'b1;
    tick();
    bus2.i_Init = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("cont gap", {bus2.o_Main_FSM, bus2.o_Erase}, {2'd0, 1'b1});
    tick();
    check("cont restart", {bus2.o_Main_FSM, bus2.o_Expose}, {2'd1, 1'b1});
    bus2.i_Cont = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("cont stop", {bus2.o_Main_FSM, bus2.o_Erase}, {2'd0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("cont stays idle %0d", i), bus2.o_Main_FSM, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
